// File: rtl/egress_scheduler.sv
// Egress scheduler: round-robin drain of four egress FIFOs into one ready/valid output, with per-channel word counters.
// Define EGRESS_PARITY_EN to widen data_out by one bit carrying even parity of the word in its MSB.
module egress_scheduler #(
    parameter int WORD_SIZE = 10,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [WORD_SIZE-1:0] fifo5_data_out,
    input  logic [WORD_SIZE-1:0] fifo6_data_out,
    input  logic [WORD_SIZE-1:0] fifo7_data_out,
    input  logic [WORD_SIZE-1:0] fifo8_data_out,
    input  logic [3:0]           fifo_empty,
    output logic                 fifo5_rd,
    output logic                 fifo6_rd,
    output logic                 fifo7_rd,
    output logic                 fifo8_rd,
`ifdef EGRESS_PARITY_EN
    output logic [WORD_SIZE:0]   data_out,
`else
    output logic [WORD_SIZE-1:0] data_out,
`endif
    output logic [1:0]           dest_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic [CNT_W-1:0]     cnt_out,
    output logic                 cnt_valid,
    output logic                 idle_out
);

`ifdef EGRESS_PARITY_EN
    localparam int OUT_W = WORD_SIZE + 1;
`else
    localparam int OUT_W = WORD_SIZE;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               run_q, run_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [1:0]         dest_q, dest_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];
    logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
    logic               cnt_valid_q, cnt_valid_d;

    logic [1:0]         win;
    logic [1:0]         cand;
    logic               found;
    logic               accept;
    logic               issue;
    logic [3:0]         rd_vec;
    logic [WORD_SIZE-1:0] grant_word;

    // Round-robin search starting at ptr_q; found doubles as "some FIFO has data".
    always_comb begin
        win   = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && !fifo_empty[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_word = fifo5_data_out;
        case (gnt_q)
            2'd0:    grant_word = fifo5_data_out;
            2'd1:    grant_word = fifo6_data_out;
            2'd2:    grant_word = fifo7_data_out;
            default: grant_word = fifo8_data_out;
        endcase
    end

    // The read strobe is combinational so FIFO data lands exactly in the RD cycle;
    // run_q keeps it quiet until the first clock edge after reset release.
    assign accept = valid_q && ready_in;
    assign issue  = run_q && found &&
                    ((state_q == IDLE) || ((state_q == OUT) && accept));
    assign rd_vec = issue ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        run_d       = 1'b1;
        data_d      = data_q;
        dest_d      = dest_q;
        valid_d     = valid_q;
        cnt_out_d   = cnt_out_q;
        cnt_valid_d = req;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = RD;
                    gnt_d   = win;
                    ptr_d   = win + 2'd1;
                end
            end
            RD: begin
`ifdef EGRESS_PARITY_EN
                data_d = {^grant_word, grant_word};
`else
                data_d = grant_word;
`endif
                dest_d  = gnt_q;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (accept) begin
                    valid_d = 1'b0;
                    if (issue) begin
                        state_d = RD;
                        gnt_d   = win;
                        ptr_d   = win + 2'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Query reads cnt_q, so a same-cycle increment is not yet visible.
        if (req) begin
            cnt_out_d = cnt_q[idx];
        end
        if (accept) begin
            cnt_d[dest_q] = cnt_q[dest_q] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            run_q       <= 1'b0;
            data_q      <= '0;
            dest_q      <= '0;
            valid_q     <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            run_q       <= run_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            valid_q     <= valid_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign fifo5_rd  = rd_vec[0];
    assign fifo6_rd  = rd_vec[1];
    assign fifo7_rd  = rd_vec[2];
    assign fifo8_rd  = rd_vec[3];
    assign data_out  = data_q;
    assign dest_out  = dest_q;
    assign valid_out = valid_q;
    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;
    assign idle_out  = (state_q == IDLE) && (fifo_empty == 4'b1111);

endmodule

// File: tb/tb_egress_scheduler.sv
// Bench for egress_scheduler: queue-backed FIFO models, a transaction-level reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_egress_scheduler;

    localparam int WS = 10;
    localparam int CW = 5;
`ifdef EGRESS_PARITY_EN
    localparam int OW = WS + 1;
`else
    localparam int OW = WS;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic [WS-1:0] fdata [4];
    logic [3:0]    fifo_empty;
    logic          f5, f6, f7, f8;
    logic [OW-1:0] data_out;
    logic [1:0]    dest_out;
    logic          valid_out;
    logic          ready_in;
    logic          req;
    logic [1:0]    idx;
    logic [CW-1:0] cnt_out;
    logic          cnt_valid;
    logic          idle_out;
    logic [3:0]    rd_vec;

    always #5 clk = ~clk;

    egress_scheduler #(.WORD_SIZE(WS), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .fifo5_data_out (fdata[0]),
        .fifo6_data_out (fdata[1]),
        .fifo7_data_out (fdata[2]),
        .fifo8_data_out (fdata[3]),
        .fifo_empty     (fifo_empty),
        .fifo5_rd       (f5),
        .fifo6_rd       (f6),
        .fifo7_rd       (f7),
        .fifo8_rd       (f8),
        .data_out       (data_out),
        .dest_out       (dest_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .req            (req),
        .idx            (idx),
        .cnt_out        (cnt_out),
        .cnt_valid      (cnt_valid),
        .idle_out       (idle_out)
    );

    assign rd_vec = {f8, f7, f6, f5};

    logic [WS-1:0] fq0[$];
    logic [WS-1:0] fq1[$];
    logic [WS-1:0] fq2[$];
    logic [WS-1:0] fq3[$];

    int         vectors;
    int         miscompares;
    int         cyc;
    int         rd_count [4];
    logic [3:0] pend_rd;

    // Reference model state: one word in flight at most, aged from its read strobe.
    logic [1:0]    m_ptr;
    logic [1:0]    m_dest;
    logic          m_busy;
    logic          m_started;
    int            m_age;
    logic [OW-1:0] m_word;
    logic [CW-1:0] m_cnt [4];
    logic [CW-1:0] m_cnt_out;
    logic          m_cnt_valid;

    logic          c_exp_valid;
    logic          c_accept;
    logic          c_found;
    logic [1:0]    c_win;
    logic [3:0]    c_exp_rd;

    function automatic int qsize(input int ch);
        case (ch)
            0:       return fq0.size();
            1:       return fq1.size();
            2:       return fq2.size();
            default: return fq3.size();
        endcase
    endfunction

    function automatic logic [WS-1:0] qfront(input int ch);
        if (qsize(ch) == 0) return '0;
        case (ch)
            0:       return fq0[0];
            1:       return fq1[0];
            2:       return fq2[0];
            default: return fq3[0];
        endcase
    endfunction

    function automatic logic [OW-1:0] expWord(input logic [WS-1:0] w);
`ifdef EGRESS_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    task automatic refreshEmpty();
        fifo_empty = {qsize(3) == 0, qsize(2) == 0, qsize(1) == 0, qsize(0) == 0};
    endtask

    task automatic pushWord(input int ch, input logic [WS-1:0] w);
        case (ch)
            0:       fq0.push_back(w);
            1:       fq1.push_back(w);
            2:       fq2.push_back(w);
            default: fq3.push_back(w);
        endcase
        refreshEmpty();
    endtask

    task automatic popWord(input int ch, output logic [WS-1:0] w);
        w = '0;
        if (qsize(ch) > 0) begin
            case (ch)
                0:       w = fq0.pop_front();
                1:       w = fq1.pop_front();
                2:       w = fq2.pop_front();
                default: w = fq3.pop_front();
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: FIFOs react to strobes seen last cycle, then new inputs are driven.
    task automatic applyStimulus(input logic rdy, input logic rq, input logic [1:0] ix);
        logic [WS-1:0] w;
        @(posedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < 4; ch++) begin
            if (pend_rd[ch]) begin
                popWord(ch, w);
                fdata[ch] = w;
            end
        end
        ready_in = rdy;
        req      = rq;
        idx      = ix;
        refreshEmpty();
        #1;
    endtask

    task automatic doReset();
        reset_L  = 1'b0;
        ready_in = 1'b0;
        req      = 1'b0;
        idx      = 2'd0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        #1;
    endtask

    task automatic drainIdle(input int max);
        int n;
        n = 0;
        while (!((qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0) && idle_out) && n < max) begin
            applyStimulus(1'b1, 1'b0, 2'd0);
            n++;
        end
        checkOutput("drain to idle within budget", (n < max), 1);
    endtask

    task automatic waitValid(input int max);
        int n;
        n = 0;
        while (!valid_out && n < max) begin
            applyStimulus(1'b0, 1'b0, 2'd0);
            n++;
        end
        checkOutput("valid_out within budget", valid_out, 1);
    endtask

    // Single compare process: checks every DUT output against the model, then advances the model.
    always @(negedge clk) begin
        if (!reset_L) begin
            checkOutput("reset valid_out", valid_out, 0);
            checkOutput("reset data_out", data_out, 0);
            checkOutput("reset dest_out", dest_out, 0);
            checkOutput("reset rd strobes", rd_vec, 0);
            checkOutput("reset cnt_out", cnt_out, 0);
            checkOutput("reset cnt_valid", cnt_valid, 0);
            m_ptr       = 2'd0;
            m_dest      = 2'd0;
            m_busy      = 1'b0;
            m_started   = 1'b0;
            m_age       = 0;
            m_word      = '0;
            m_cnt_out   = '0;
            m_cnt_valid = 1'b0;
            for (int k = 0; k < 4; k++) m_cnt[k] = '0;
            pend_rd = 4'b0000;
        end else begin
            c_exp_valid = m_busy && (m_age >= 2);
            c_accept    = c_exp_valid && ready_in;
            c_found     = 1'b0;
            c_win       = 2'd0;
            c_exp_rd    = 4'b0000;
            if (m_started && (!m_busy || c_accept)) begin
                for (int i = 0; i < 4; i++) begin
                    if (!c_found && !fifo_empty[(int'(m_ptr) + i) % 4]) begin
                        c_found = 1'b1;
                        c_win   = 2'((int'(m_ptr) + i) % 4);
                    end
                end
            end
            if (c_found) c_exp_rd[c_win] = 1'b1;

            checkOutput("model valid_out", valid_out, c_exp_valid);
            if (c_exp_valid) begin
                checkOutput("model data_out", data_out, m_word);
                checkOutput("model dest_out", dest_out, m_dest);
            end
            checkOutput("model rd strobes", rd_vec, c_exp_rd);
            checkOutput("model idle_out", idle_out, (!m_busy && fifo_empty == 4'b1111));
            checkOutput("model cnt_valid", cnt_valid, m_cnt_valid);
            checkOutput("model cnt_out", cnt_out, m_cnt_out);

            m_cnt_valid = req;
            if (req) m_cnt_out = m_cnt[idx];
            if (c_accept) begin
                m_cnt[m_dest] = m_cnt[m_dest] + CW'(1);
                m_busy        = 1'b0;
            end
            if (c_found) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_word = expWord(qfront(int'(c_win)));
                m_dest = c_win;
                m_ptr  = c_win + 2'd1;
            end else if (m_busy && m_age < 2) begin
                m_age++;
            end
            m_started = 1'b1;
            pend_rd   = rd_vec;
            for (int ch = 0; ch < 4; ch++) begin
                if (rd_vec[ch]) rd_count[ch]++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            dests [5];
        int            cycs  [5];
        int            exp_dests [5];
        int            n;
        int            rd_base;
        logic [OW-1:0] lit;

        exp_dests   = '{0, 1, 2, 3, 0};
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        pend_rd     = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rd_count[k] = 0;
            fdata[k]    = '0;
        end
        reset_L    = 1'b0;
        ready_in   = 1'b0;
        req        = 1'b0;
        idx        = 2'd0;
        fifo_empty = 4'b1111;

        // Reset with all FIFOs empty.
        repeat (3) @(posedge clk);
        #2;
        checkOutput("T1 idle_out in reset", idle_out, 1);
        checkOutput("T1 valid_out in reset", valid_out, 0);
        checkOutput("T1 data_out in reset", data_out, 0);
        checkOutput("T1 rd in reset", rd_vec, 0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkOutput("T1 idle_out after release", idle_out, 1);

        // All four FIFOs loaded, downstream always ready.
        for (int ch = 0; ch < 4; ch++) begin
            pushWord(ch, WS'($urandom));
            pushWord(ch, WS'($urandom));
        end
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd0);
            if (valid_out) begin
                dests[n] = int'(dest_out);
                cycs[n]  = cyc;
                n++;
            end
        end
        checkOutput("T2 words seen", n, 5);
        for (int i = 0; i < n; i++) begin
            checkOutput("T2 dest order", dests[i], exp_dests[i]);
            if (i > 0) checkOutput("T2 valid spacing", cycs[i] - cycs[i-1], 2);
        end
        drainIdle(100);

        // 33 words through fifo7, then query its counter (wraps at 32).
        doReset();
        for (int i = 0; i < 33; i++) pushWord(2, WS'($urandom));
        drainIdle(200);
        applyStimulus(1'b0, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("T4 cnt_out after 33", cnt_out, 1);
        checkOutput("T4 cnt_valid", cnt_valid, 1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("T4 cnt_valid drops", cnt_valid, 0);
        checkOutput("T4 cnt_out holds", cnt_out, 1);

        // Back-pressure: one word from fifo6 must hold for five cycles.
        rd_base = rd_count[1];
        pushWord(1, 10'h2A5);
        waitValid(20);
        for (int i = 0; i < 5; i++) begin
            checkOutput("T3 data_out stable", data_out, expWord(10'h2A5));
            checkOutput("T3 dest_out stable", dest_out, 1);
            checkOutput("T3 valid_out stable", valid_out, 1);
            applyStimulus(1'b0, 1'b0, 2'd0);
        end
        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("T3 single fifo6 pulse", rd_count[1] - rd_base, 1);
        checkOutput("T3 valid after accept", valid_out, 0);

        // Reset while a word from fifo6 waits in the output register.
        pushWord(1, WS'($urandom));
        waitValid(20);
        reset_L = 1'b0;
        #1;
        checkOutput("T5 valid_out drops async", valid_out, 0);
        checkOutput("T5 cnt_out cleared", cnt_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        #1;
        pushWord(0, WS'($urandom));
        pushWord(2, WS'($urandom));
        applyStimulus(1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("T5 counter1 cleared", cnt_out, 0);
        checkOutput("T5 cnt_valid", cnt_valid, 1);
        waitValid(20);
        checkOutput("T5 ptr restarts at fifo5", dest_out, 0);
        drainIdle(100);

        // Parity bit on a word with three ones.
        pushWord(0, 10'h007);
        waitValid(20);
`ifdef EGRESS_PARITY_EN
        lit = 11'h407;
`else
        lit = 10'h007;
`endif
        checkOutput("T6 data_out 007", data_out, lit);
        drainIdle(100);

        // Random traffic, back-pressure and queries.
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 3) == 0 && qsize(ch) < 6) pushWord(ch, WS'($urandom));
            end
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                          2'($urandom_range(0, 3)));
        end
        drainIdle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/egress_scheduler.md
EGRESS_SCHEDULER -- requirements
Module: egress_scheduler

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 10, egress word width.
REQ-002 SHALL have parameter CNT_W, default 5, per-channel word-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_L  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifoN_data_out (N=5..8)  input  WORD_SIZE each  egress FIFO read data, valid one cycle after fifoN_rd.
REQ-006 SHALL have port fifo_empty  input  4  egress FIFO empty flags; bit 0 = fifo5 ... bit 3 = fifo8.
REQ-007 SHALL have port fifoN_rd (N=5..8)  output  1 each  one-cycle read strobe to egress FIFO N.
REQ-008 SHALL have port data_out  output  WORD_SIZE (WORD_SIZE+1 with parity)  scheduled word.
REQ-009 SHALL have port dest_out  output  2  source channel of data_out (0 = fifo5).
REQ-010 SHALL have port valid_out  output  1  data_out/dest_out valid.
REQ-011 SHALL have port ready_in  input  1  downstream accepts when valid_out && ready_in.
REQ-012 SHALL have port req  input  1  counter query request.
REQ-013 SHALL have port idx  input  2  counter index for query.
REQ-014 SHALL have port cnt_out  output  CNT_W  queried counter value.
REQ-015 SHALL have port cnt_valid  output  1  cnt_out valid.
REQ-016 SHALL have port idle_out  output  1  high when FSM in IDLE and fifo_empty == 4'b1111.

Function
REQ-017 SHALL implement FSM states IDLE, RD, OUT.
REQ-018 IDLE: if any fifo_empty bit low, SHALL assert fifoN_rd for the round-robin winner for one cycle, go RD; else stay IDLE.
REQ-019 Round-robin: SHALL search channels starting at pointer ptr (reset 0), wrapping 3->0; after a grant to k, ptr SHALL become (k+1) mod 4.
REQ-020 RD: SHALL capture fifoN_data_out of the granted channel into the output register, set dest_out = k, assert valid_out next cycle, go OUT.
REQ-021 OUT: data_out, dest_out, valid_out SHALL hold stable while ready_in low.
REQ-022 OUT on acceptance: if any channel non-empty, SHALL issue next rd in the same cycle and go RD (sustained 1 word / 2 cycles); else deassert valid_out, go IDLE.
REQ-023 SHALL never assert more than one fifoN_rd per cycle, never assert rd to a channel whose empty flag is high, never assert rd in RD or OUT without acceptance.
REQ-024 Counter k SHALL increment by 1 on each acceptance with dest_out == k, wrapping 2^CNT_W-1 -> 0.
REQ-025 req high SHALL produce cnt_out = counter[idx] and cnt_valid = 1 on the next cycle; req low -> cnt_valid = 0, cnt_out holds.
REQ-026 Query and increment of the same counter in one cycle SHALL return the pre-increment value.

Reset
REQ-027 reset_L low SHALL asynchronously force: FSM IDLE, ptr 0, all fifoN_rd 0, data_out 0, dest_out 0, valid_out 0, all counters 0, cnt_out 0, cnt_valid 0.
REQ-028 Reset during RD or OUT SHALL discard the pending word; no rd strobe before the first rising edge after release.

Configuration
REQ-029 With macro EGRESS_PARITY_EN defined, data_out SHALL be WORD_SIZE+1 bits, MSB = even parity (XOR) of the captured word; undefined, data_out SHALL be WORD_SIZE bits, no parity.

Verification
REQ-030 Reset, fifo_empty=4'b1111 -> all outputs 0, idle_out=1, no rd.
REQ-031 All four FIFOs non-empty, ready_in=1 -> grants 5,6,7,8,5 in order, valid_out every other cycle, dest_out 0,1,2,3,0.
REQ-032 fifo6 holds 10'h2A5, ready_in low 5 cycles -> data_out=10'h2A5, dest_out=1 stable 5 cycles, single fifo6_rd pulse.
REQ-033 33 accepted words from fifo7, then req=1, idx=2 -> next cycle cnt_out=1, cnt_valid=1.
REQ-034 reset_L low while in OUT -> valid_out drops immediately, counters 0, ptr 0.
REQ-035 EGRESS_PARITY_EN defined, word 10'h007 -> data_out=11'h407; undefined -> 10'h007.
